// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid pipeline register.
// Holds the occupancy FSM encoding and its width.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the skid register: reset, flush clear, load.
// Flush always kills ctrl; data is kept unless CLR_DATA_ON_FLUSH is set.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int CTRL_W            = 16,
  parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= '0;
      ctrl <= '0;
    end else if (flush) begin
      ctrl <= '0;
      if (CLR_DATA_ON_FLUSH)
        data <= '0;
    end else if (load) begin
      data <= data_in;
      ctrl <= ctrl_in;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with flush and registered ready.
// Head of the queue lives in main; skid only fills under backpressure.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int CTRL_W            = 16,
  parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [OCC_W-1:0]  o_occupancy
);

  state_t state;

  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [CTRL_W-1:0] main_c;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // ready depends on state only, never on i_ready
  assign o_ready     = (state != FULL);
  assign o_valid     = (state != EMPTY);
  assign o_occupancy = OCC_W'(state);

  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    unique case (state)
      EMPTY: main_load = in_xfer;
      ONE: begin
        main_load = in_xfer && out_xfer;
        skid_load = in_xfer && !out_xfer;
      end
      FULL:    main_load = out_xfer;
      default: main_load = 1'b0;
    endcase
  end

  assign main_d = (state == FULL) ? skid_data : i_data;
  assign main_c = (state == FULL) ? skid_ctrl : i_ctrl;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= EMPTY;
    end else if (i_flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY:
          if (in_xfer) state <= ONE;
        ONE:
          if (in_xfer && !out_xfer)
            state <= FULL;
          else if (!in_xfer && out_xfer)
            state <= EMPTY;
        FULL:
          if (out_xfer) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_skid_entry #(
    .DATA_W            (DATA_W),
    .CTRL_W            (CTRL_W),
    .CLR_DATA_ON_FLUSH (CLR_DATA_ON_FLUSH)
  ) u_main (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .flush   (i_flush),
    .load    (main_load),
    .data_in (main_d),
    .ctrl_in (main_c),
    .data    (o_data),
    .ctrl    (o_ctrl)
  );

  pipe_skid_entry #(
    .DATA_W            (DATA_W),
    .CTRL_W            (CTRL_W),
    .CLR_DATA_ON_FLUSH (CLR_DATA_ON_FLUSH)
  ) u_skid (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .flush   (i_flush),
    .load    (skid_load),
    .data_in (i_data),
    .ctrl_in (i_ctrl),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg; two instances share stimulus,
// one holding data on flush and one clearing it.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] din;
  logic [7:0]  cin;

  logic        rdy0, vld0, rdy1, vld1;
  logic [31:0] dat0, dat1;
  logic [7:0]  ctl0, ctl1;
  logic [1:0]  occ0, occ1;

  int compared;
  int mismatched;

  pipe_skid_reg #(
    .DATA_W(32), .CTRL_W(8), .CLR_DATA_ON_FLUSH(1'b0)
  ) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(rdy0), .i_data(din), .i_ctrl(cin),
    .o_valid(vld0), .i_ready(ready), .o_data(dat0), .o_ctrl(ctl0),
    .o_occupancy(occ0)
  );

  pipe_skid_reg #(
    .DATA_W(32), .CTRL_W(8), .CLR_DATA_ON_FLUSH(1'b1)
  ) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(rdy1), .i_data(din), .i_ctrl(cin),
    .o_valid(vld1), .i_ready(ready), .o_data(dat1), .o_ctrl(ctl1),
    .o_occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [7:0] c);
    valid = v;
    din   = d;
    cin   = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
    drive(1'b1, 32'hDEAD, 8'hFF);
    step();
    compared++;
    if (vld0 !== 1'b0 || occ0 !== 2'd0 || rdy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_flags: got v=%b occ=%0d r=%b want 0 0 1",
               vld0, occ0, rdy0);
    end
    compared++;
    if (dat0 !== 32'h0 || ctl0 !== 8'h0) begin
      mismatched++;
      $display("FAIL reset_payload: got %h/%h want 0/0", dat0, ctl0);
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    step();
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h100; vals[1] = 32'h104; vals[2] = 32'h108;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (rdy0 !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, rdy0);
      end
      drive(1'b1, vals[i], 8'(i + 1));
      step();
      compared++;
      if (vld0 !== 1'b1 || dat0 !== vals[i] || ctl0 !== 8'(i + 1)) begin
        mismatched++;
        $display("FAIL stream_out[%0d]: got v=%b %h/%h want 1 %h/%h",
                 i, vld0, dat0, ctl0, vals[i], 8'(i + 1));
      end
    end
    drive(1'b0, 32'h0, 8'h0);
    step();
    compared++;
    if (vld0 !== 1'b0 || occ0 !== 2'd0) begin
      mismatched++;
      $display("FAIL stream_drain: got v=%b occ=%0d want 0 0", vld0, occ0);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    drive(1'b1, 32'hA, 8'h0A);
    step();
    compared++;
    if (occ0 !== 2'd1 || dat0 !== 32'hA || rdy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_one: got occ=%0d d=%h r=%b want 1 A 1",
               occ0, dat0, rdy0);
    end
    drive(1'b1, 32'hB, 8'h0B);
    step();
    compared++;
    if (occ0 !== 2'd2 || dat0 !== 32'hA || rdy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_full: got occ=%0d d=%h r=%b want 2 A 0",
               occ0, dat0, rdy0);
    end
    drive(1'b1, 32'hC, 8'h0C);
    step();
    compared++;
    if (occ0 !== 2'd2 || dat0 !== 32'hA || ctl0 !== 8'h0A) begin
      mismatched++;
      $display("FAIL bp_hold: got occ=%0d %h/%h want 2 A/0A",
               occ0, dat0, ctl0);
    end
    ready = 1'b1;
    step();
    compared++;
    if (occ0 !== 2'd1 || dat0 !== 32'hB || ctl0 !== 8'h0B) begin
      mismatched++;
      $display("FAIL bp_out_b: got occ=%0d %h/%h want 1 B/0B",
               occ0, dat0, ctl0);
    end
    step();
    compared++;
    if (occ0 !== 2'd1 || dat0 !== 32'hC || ctl0 !== 8'h0C) begin
      mismatched++;
      $display("FAIL bp_out_c: got occ=%0d %h/%h want 1 C/0C",
               occ0, dat0, ctl0);
    end
    drive(1'b0, 32'h0, 8'h0);
    step();
    compared++;
    if (vld0 !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_drain: got v=%b want 0", vld0);
    end
  endtask

  task automatic test_flush();
    ready = 1'b0;
    drive(1'b1, 32'hE, 8'h11);
    step();
    drive(1'b1, 32'hF, 8'h22);
    step();
    compared++;
    if (occ0 !== 2'd2 || occ1 !== 2'd2) begin
      mismatched++;
      $display("FAIL flush_fill: got occ=%0d/%0d want 2/2", occ0, occ1);
    end
    flush = 1'b1;
    drive(1'b1, 32'hD, 8'h33);
    step();
    compared++;
    if (vld0 !== 1'b0 || occ0 !== 2'd0 || rdy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_state: got v=%b occ=%0d r=%b want 0 0 1",
               vld0, occ0, rdy0);
    end
    compared++;
    if (dat0 !== 32'hE || ctl0 !== 8'h0) begin
      mismatched++;
      $display("FAIL flush_hold: got %h/%h want E/00", dat0, ctl0);
    end
    compared++;
    if (dat1 !== 32'h0 || ctl1 !== 8'h0 || vld1 !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_clr: got v=%b %h/%h want 0 0/00",
               vld1, dat1, ctl1);
    end
    flush = 1'b0;
    ready = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    step();
    compared++;
    if (vld0 !== 1'b0 || dat0 !== 32'hE || vld1 !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_no_d: got v=%b/%b d=%h want 0/0 E",
               vld0, vld1, dat0);
    end
  endtask

  task automatic test_simul();
    ready = 1'b1;
    drive(1'b1, 32'h20, 8'h44);
    step();
    compared++;
    if (dat0 !== 32'h20 || occ0 !== 2'd1) begin
      mismatched++;
      $display("FAIL simul_load: got %h occ=%0d want 20 1", dat0, occ0);
    end
    drive(1'b1, 32'h24, 8'h55);
    step();
    compared++;
    if (dat0 !== 32'h24 || ctl0 !== 8'h55 || occ0 !== 2'd1) begin
      mismatched++;
      $display("FAIL simul_swap: got %h/%h occ=%0d want 24/55 1",
               dat0, ctl0, occ0);
    end
    drive(1'b0, 32'h0, 8'h0);
    step();
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    drive(1'b1, 32'h30, 8'h66);
    step();
    drive(1'b1, 32'h34, 8'h77);
    step();
    compared++;
    if (occ0 !== 2'd2) begin
      mismatched++;
      $display("FAIL rmid_fill: got occ=%0d want 2", occ0);
    end
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    compared++;
    if (vld0 !== 1'b0 || occ0 !== 2'd0 || rdy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_flags: got v=%b occ=%0d r=%b want 0 0 1",
               vld0, occ0, rdy0);
    end
    compared++;
    if (dat0 !== 32'h0 || ctl0 !== 8'h0) begin
      mismatched++;
      $display("FAIL rmid_payload: got %h/%h want 0/00", dat0, ctl0);
    end
    rst_n = 1'b1;
    flush = 1'b0;
    ready = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    step();
    compared++;
    if (vld0 !== 1'b0) begin
      mismatched++;
      $display("FAIL rmid_after: got v=%b want 0", vld0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
